// File: rtl/unidad_control_pkg.sv
// Shared encodings for the main control unit.
// Opcode constants, ALU/write-back select codes and the decode bundle.
package unidad_control_pkg;

    localparam logic [6:0] OP_R     = 7'b0110011;
    localparam logic [6:0] OP_I     = 7'b0010011;
    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam logic [6:0] OP_LUI   = 7'b0110111;
    localparam logic [6:0] OP_NOP   = 7'b0000000;

    localparam logic [2:0] F3_ADD = 3'b000;
    localparam logic [2:0] F3_SRL = 3'b101;
    localparam logic [2:0] F3_OR  = 3'b110;
    localparam logic [2:0] F3_AND = 3'b111;

    typedef enum logic [1:0] {
        ALU_ADD = 2'b00,
        ALU_SRL = 2'b01,
        ALU_OR  = 2'b10,
        ALU_AND = 2'b11
    } alu_op_t;

    typedef enum logic [1:0] {
        WB_ALU = 2'b00,
        WB_MEM = 2'b01,
        WB_IMM = 2'b10
    } wb_sel_t;

    typedef enum logic {
        IMM_I = 1'b0,
        IMM_S = 1'b1
    } imm_sel_t;

    typedef struct packed {
        logic [1:0] alu_reg;
        logic [1:0] alu_op;
        logic       alu_src;
        logic       we_mem;
        logic       we_reg;
        logic       imm_src;
        logic       illegal;
    } ctrl_t;

    localparam ctrl_t CTRL_ZERO = '0;

endpackage

// File: rtl/unidad_control_decode.sv
// Combinational opcode/funct3 decode into the control bundle.
// Unsupported encodings yield an all-zero bundle with only illegal set.
module control_decode
    import unidad_control_pkg::*;
(
    input  logic [6:0] opcode,
    input  logic [2:0] funct,
    output ctrl_t      ctrl
);

    logic       alu_ok;
    logic [1:0] alu_fn;

    always_comb begin
        alu_ok = 1'b1;
        alu_fn = ALU_ADD;
        unique case (funct)
            F3_ADD:  alu_fn = ALU_ADD;
            F3_SRL:  alu_fn = ALU_SRL;
            F3_OR:   alu_fn = ALU_OR;
            F3_AND:  alu_fn = ALU_AND;
            default: alu_ok = 1'b0;
        endcase
    end

    always_comb begin
        ctrl = CTRL_ZERO;
        case (opcode)
            OP_R, OP_I: begin
                if (alu_ok) begin
                    ctrl.alu_reg = WB_ALU;
                    ctrl.alu_op  = alu_fn;
                    ctrl.alu_src = (opcode == OP_I);
                    ctrl.we_reg  = 1'b1;
                    ctrl.imm_src = IMM_I;
                end else begin
                    ctrl.illegal = 1'b1;
                end
            end
            OP_LOAD: begin
                ctrl.alu_reg = WB_MEM;
                ctrl.alu_src = 1'b1;
                ctrl.we_reg  = 1'b1;
                ctrl.imm_src = IMM_I;
            end
            OP_STORE: begin
                ctrl.alu_reg = WB_ALU;
                ctrl.alu_src = 1'b1;
                ctrl.we_mem  = 1'b1;
                ctrl.imm_src = IMM_S;
            end
            OP_LUI: begin
                ctrl.alu_reg = WB_IMM;
                ctrl.alu_src = 1'b1;
                ctrl.we_reg  = 1'b1;
                ctrl.imm_src = IMM_I;
            end
            OP_NOP:  ctrl = CTRL_ZERO;
            default: ctrl.illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/unidad_control.sv
// Main control unit: registered outputs of the opcode/funct3 decode.
// One cycle of latency; synchronous reset clears every output.
module unidad_control
    import unidad_control_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [6:0] opcode,
    input  logic [2:0] funct,
    output logic [1:0] ALUreg,
    output logic [1:0] ALUop,
    output logic       ALUsrc,
    output logic       WEmem,
    output logic       WEreg,
    output logic       immsrc,
    output logic       illegal
);

    ctrl_t dec;
    ctrl_t q;

    control_decode u_decode (
        .opcode (opcode),
        .funct  (funct),
        .ctrl   (dec)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            q <= CTRL_ZERO;
        end else begin
            q <= dec;
        end
    end

    assign ALUreg  = q.alu_reg;
    assign ALUop   = q.alu_op;
    assign ALUsrc  = q.alu_src;
    assign WEmem   = q.we_mem;
    assign WEreg   = q.we_reg;
    assign immsrc  = q.imm_src;
    assign illegal = q.illegal;

endmodule

// File: tb/tb_unidad_control.sv
// Directed bench for unidad_control with hand-computed expected vectors.
// Vector layout: {ALUreg, ALUop, ALUsrc, WEmem, WEreg, immsrc, illegal}.
module tb_unidad_control;

    logic       clk;
    logic       rst;
    logic [6:0] opcode;
    logic [2:0] funct;
    logic [1:0] ALUreg;
    logic [1:0] ALUop;
    logic       ALUsrc;
    logic       WEmem;
    logic       WEreg;
    logic       immsrc;
    logic       illegal;

    int checks = 0;
    int errors = 0;

    unidad_control dut (
        .clk     (clk),
        .rst     (rst),
        .opcode  (opcode),
        .funct   (funct),
        .ALUreg  (ALUreg),
        .ALUop   (ALUop),
        .ALUsrc  (ALUsrc),
        .WEmem   (WEmem),
        .WEreg   (WEreg),
        .immsrc  (immsrc),
        .illegal (illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step(input logic r, input logic [6:0] op,
                        input logic [2:0] f, input string tag,
                        input logic [8:0] exp);
        logic [8:0] obs;
        rst    = r;
        opcode = op;
        funct  = f;
        @(posedge clk);
        #1;
        obs = {ALUreg, ALUop, ALUsrc, WEmem, WEreg, immsrc, illegal};
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    initial begin
        rst    = 1'b1;
        opcode = 7'b0110011;
        funct  = 3'b111;
        // reset held two edges with a valid R-type present
        step(1'b1, 7'b0110011, 3'b111, "reset_0", 9'b00_00_0_0_0_0_0);
        step(1'b1, 7'b0110011, 3'b111, "reset_1", 9'b00_00_0_0_0_0_0);
        step(1'b0, 7'b0110011, 3'b111, "r_and",   9'b00_11_0_0_1_0_0);
        step(1'b0, 7'b0110011, 3'b000, "r_add",   9'b00_00_0_0_1_0_0);
        step(1'b0, 7'b0110011, 3'b101, "r_srl",   9'b00_01_0_0_1_0_0);
        step(1'b0, 7'b0110011, 3'b010, "r_bad",   9'b00_00_0_0_0_0_1);
        step(1'b0, 7'b0000011, 3'b101, "load",    9'b01_00_1_0_1_0_0);
        step(1'b0, 7'b0100011, 3'b010, "store",   9'b00_00_1_1_0_1_0);
        step(1'b0, 7'b0110111, 3'b110, "lui",     9'b10_00_1_0_1_0_0);
        step(1'b0, 7'b0010011, 3'b000, "i_add",   9'b00_00_1_0_1_0_0);
        step(1'b0, 7'b0010011, 3'b101, "i_srl",   9'b00_01_1_0_1_0_0);
        step(1'b0, 7'b0010011, 3'b110, "i_or",    9'b00_10_1_0_1_0_0);
        step(1'b0, 7'b0010011, 3'b111, "i_and",   9'b00_11_1_0_1_0_0);
        step(1'b0, 7'b0010011, 3'b001, "i_bad",   9'b00_00_0_0_0_0_1);
        step(1'b0, 7'b0010011, 3'b100, "i_bad4",  9'b00_00_0_0_0_0_1);
        step(1'b0, 7'b1111111, 3'b000, "op_ones", 9'b00_00_0_0_0_0_1);
        step(1'b0, 7'b0000000, 3'b111, "bubble",  9'b00_00_0_0_0_0_0);
        // low opcode bits must be compared in full
        step(1'b0, 7'b0110001, 3'b000, "r_lo01",  9'b00_00_0_0_0_0_1);
        step(1'b0, 7'b0000010, 3'b000, "ld_lo10", 9'b00_00_0_0_0_0_1);
        step(1'b0, 7'b0100000, 3'b000, "st_lo00", 9'b00_00_0_0_0_0_1);
        step(1'b0, 7'b0110111, 3'b000, "lui_pre", 9'b10_00_1_0_1_0_0);
        step(1'b1, 7'b0110111, 3'b000, "rst_mid", 9'b00_00_0_0_0_0_0);
        step(1'b0, 7'b0100011, 3'b000, "post_st", 9'b00_00_1_1_0_1_0);
        step(1'b0, 7'b0000011, 3'b000, "post_ld", 9'b01_00_1_0_1_0_0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/unidad_control.md
UNIDAD_CONTROL -- requirements
Module: unidad_control

Interface
REQ-001 SHALL have one clock and a synchronous, active-high reset: clk and rst.
REQ-002 clk  input  1  rising-edge clock for all registered outputs.
REQ-003 rst  input  1  synchronous, active-high; sampled on rising clk.
REQ-004 opcode  input  7  instruction bits [6:0].
REQ-005 funct  input  3  instruction bits [14:12] (funct3).
REQ-006 ALUreg  output  2  write-back source select: 00 ALU result, 01 memory read data, 10 U-immediate (LUI), 11 reserved/never driven.
REQ-007 ALUop  output  2  ALU operation: 00 ADD, 01 SRL, 10 OR, 11 AND.
REQ-008 ALUsrc  output  1  ALU operand B: 0 register rs2, 1 immediate.
REQ-009 WEmem  output  1  data-memory write enable.
REQ-010 WEreg  output  1  register-file write enable.
REQ-011 immsrc  output  1  immediate format: 0 I-type (inst[31:20]), 1 S-type (inst[31:25],inst[11:7]).
REQ-012 illegal  output  1  unsupported opcode/funct flag.

Function
REQ-013 All outputs SHALL be registered; a decode of opcode/funct presented before edge N SHALL appear on outputs after edge N (latency 1 cycle), held until the next edge.
REQ-014 R-type 0110011: ALUreg=00, ALUsrc=0, WEreg=1, WEmem=0, immsrc=0, ALUop from funct.
REQ-015 I-ALU 0010011: ALUreg=00, ALUsrc=1, WEreg=1, WEmem=0, immsrc=0, ALUop from funct.
REQ-016 Funct mapping for R/I-ALU: 000->00 ADD, 101->01 SRL, 110->10 OR, 111->11 AND.
REQ-017 Load 0000011: ALUreg=01, ALUop=00, ALUsrc=1, WEreg=1, WEmem=0, immsrc=0; funct ignored.
REQ-018 Store 0100011: ALUreg=00, ALUop=00, ALUsrc=1, WEreg=0, WEmem=1, immsrc=1; funct ignored.
REQ-019 LUI 0110111: ALUreg=10, ALUop=00, ALUsrc=1, WEreg=1, WEmem=0, immsrc=0; funct ignored.
REQ-020 Opcode 0000000 is a bubble: all outputs 0, illegal=0.
REQ-021 Any other opcode, or R/I-ALU with funct in {001,010,011,100}: all outputs 0 except illegal=1; WEreg and WEmem SHALL never be 1 when illegal=1.
REQ-022 Opcode bits [1:0] SHALL be fully compared (no partial decode).

Reset
REQ-023 When rst=1 at a rising edge, all outputs SHALL become 0 on that edge, regardless of opcode/funct.
REQ-024 Reset asserted mid-stream SHALL discard the decode presented in that cycle; the first post-reset decode SHALL appear one edge after rst deasserts.

Structure
REQ-025 A shared package SHALL hold opcode constants (OP_R, OP_I, OP_LOAD, OP_STORE, OP_LUI, OP_NOP), ALUop encodings, ALUreg encodings and immsrc encodings.
REQ-026 Combinational decode SHALL live in one sub-module, control_decode, instantiated by unidad_control, which adds only the output register stage.

Verification
REQ-027 rst=1 for 2 cycles with opcode=0110011 -> all outputs 0 after each edge.
REQ-028 opcode=0110011, funct=111 -> next edge: ALUreg=00, ALUop=11, ALUsrc=0, WEreg=1, WEmem=0, illegal=0.
REQ-029 opcode=0000011 then 0100011 on consecutive cycles -> ALUreg=01, WEreg=1, WEmem=0 then ALUsrc=1, WEmem=1, WEreg=0, immsrc=1.
REQ-030 opcode=0110111 -> ALUreg=10, WEreg=1, ALUsrc=1, WEmem=0.
REQ-031 opcode=0010011, funct stepped 000,101,110,111,001 -> ALUop 00,01,10,11 with WEreg=1, then illegal=1 with WEreg=0.
REQ-032 opcode=1111111 -> illegal=1, all enables 0; opcode=0000000 -> all outputs 0, illegal=0.
